systolic_ws_array: RTL and testbench

Weight-stationary N×N systolic multiply array that sits directly downstream of `scatter_b`. It consumes the B-tile rows (`b_ins`, `b_valid`) and the `stationaryCtrl` commit pulse that `scatter_b` produces, and holds them as double-buffered stationary weights. It streams A-row vectors through the array and emits one fully reduced, deskewed C vector per input vector, in the form `C[c] = Σ_k A[k]·B[k][c]`.

---
 rtl/systolic_ws_array_if.sv | 31 +++
 rtl/systolic_ws_array.sv | 149 ++++++++++++++
 tb/tb_systolic_ws_array.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_ws_array_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_ws_array_if
// Description : Weight-load, A-vector and C-result bundle for systolic_ws_array.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_ws_array_if #(
    parameter int W     = 8,
    parameter int N     = 16,
    parameter int ACC_W = 32
);
    logic [N-1:0][W-1:0]     b_ins;
    logic                    b_valid;
    logic                    stationaryCtrl;
    logic [N-1:0][W-1:0]     a_ins;
    logic                    a_valid;
    logic [N-1:0][ACC_W-1:0] c_outs;
    logic                    c_valid;
    logic                    busy;

    modport master (
        output b_ins, b_valid, stationaryCtrl, a_ins, a_valid,
        input  c_outs, c_valid, busy
    );

    modport slave (
        input  b_ins, b_valid, stationaryCtrl, a_ins, a_valid,
        output c_outs, c_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/systolic_ws_array.sv
`default_nettype none
// ============================================================================
// Module      : systolic_ws_array
// Description : Weight-stationary NxN systolic array, double-buffered weights,
//               skewed A injection and deskewed C output (latency 2N).
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_ws_array #(
    parameter int W     = 8,
    parameter int N     = 16,
    parameter int ACC_W = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    systolic_ws_array_if.slave bus
);
    logic [N-1:0][N-1:0][W-1:0]     sh_q;
    logic [N-1:0][N-1:0][W-1:0]     wt_q;
    logic [N-1:0][W-1:0]            a_q;
    logic [2*N-1:0]                 v_q;
    logic [N-1:0][W-1:0]            w_a_sk;
    logic [N-1:0][N-1:0][W-1:0]     w_a_pe;
    logic [N-1:0][N-1:0][ACC_W-1:0] w_ps_pe;
    logic [N-1:0][ACC_W-1:0]        w_bot;
    logic [N-1:0][ACC_W-1:0]        c_outs_q;
    logic                           c_valid_q;

    // Commit reads the pre-shift shadow when it coincides with a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
            wt_q <= '0;
        end else begin
            if (bus.b_valid) begin
                sh_q[0] <= bus.b_ins;
                for (int r = 1; r < N; r++) begin
                    sh_q[r] <= sh_q[r-1];
                end
            end
            if (bus.stationaryCtrl) begin
                wt_q <= sh_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            v_q <= '0;
        end else begin
            a_q <= bus.a_valid ? bus.a_ins : '0;
            v_q <= {v_q[2*N-2:0], bus.a_valid};
        end
    end

    for (genvar gk = 0; gk < N; gk++) begin : g_skew
        if (gk == 0) begin : g_direct
            assign w_a_sk[gk] = a_q[gk];
        end else begin : g_delay
            logic [gk-1:0][W-1:0] dly_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_q <= '0;
                end else begin
                    dly_q[0] <= a_q[gk];
                    for (int j = 1; j < gk; j++) begin
                        dly_q[j] <= dly_q[j-1];
                    end
                end
            end
            assign w_a_sk[gk] = dly_q[gk-1];
        end
    end

    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_pe
            logic [W-1:0]          w_a_in;
            logic [ACC_W-1:0]      w_ps_in;
            logic signed [2*W-1:0] w_prod;
            logic [W-1:0]          pe_a_q;
            logic [ACC_W-1:0]      pe_ps_q;

            if (gc == 0) begin : g_a_edge
                assign w_a_in = w_a_sk[gr];
            end else begin : g_a_link
                assign w_a_in = w_a_pe[gr][gc-1];
            end

            if (gr == 0) begin : g_ps_edge
                assign w_ps_in = '0;
            end else begin : g_ps_link
                assign w_ps_in = w_ps_pe[gr-1][gc];
            end

            assign w_prod = $signed(w_a_in) * $signed(wt_q[gr][gc]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    pe_a_q  <= '0;
                    pe_ps_q <= '0;
                end else begin
                    pe_a_q  <= w_a_in;
                    pe_ps_q <= w_ps_in + {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};
                end
            end

            assign w_a_pe[gr][gc]  = pe_a_q;
            assign w_ps_pe[gr][gc] = pe_ps_q;
        end
    end

    // Column c leaves the bottom row c cycles late; pad to a common arrival time.
    for (genvar gc = 0; gc < N; gc++) begin : g_deskew
        localparam int DEPTH = N - 1 - gc;
        if (DEPTH == 0) begin : g_direct
            assign w_bot[gc] = w_ps_pe[N-1][gc];
        end else begin : g_delay
            logic [DEPTH-1:0][ACC_W-1:0] dsk_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dsk_q <= '0;
                end else begin
                    dsk_q[0] <= w_ps_pe[N-1][gc];
                    for (int j = 1; j < DEPTH; j++) begin
                        dsk_q[j] <= dsk_q[j-1];
                    end
                end
            end
            assign w_bot[gc] = dsk_q[DEPTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_outs_q  <= '0;
            c_valid_q <= 1'b0;
        end else begin
            c_valid_q <= v_q[2*N-1];
            if (v_q[2*N-1]) begin
                c_outs_q <= w_bot;
            end
        end
    end

    assign bus.c_outs  = c_outs_q;
    assign bus.c_valid = c_valid_q;
    assign bus.busy    = (|v_q) | c_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_systolic_ws_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_ws_array
// Description : Scoreboard bench for systolic_ws_array (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_ws_array;
    localparam int W     = 8;
    localparam int N     = 16;
    localparam int ACC_W = 32;
    localparam int LAT   = 2 * N;

    typedef logic [N-1:0][W-1:0]     row_t;
    typedef logic [N-1:0][ACC_W-1:0] cvec_t;
    typedef struct {
        cvec_t v;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    row_t shm[N];
    row_t wm[N];
    row_t t1[N], t2[N];
    row_t av[8];

    systolic_ws_array_if #(.W(W), .N(N), .ACC_W(ACC_W)) bus ();

    systolic_ws_array #(.W(W), .N(N), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented result must match the oldest expectation.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && bus.c_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_c_valid: c_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                e = sb.pop_front();
                n_tests++;
                if (bus.c_outs !== e.v) begin
                    n_fail++;
                    $display("FAIL c_outs: got %h required %h", bus.c_outs, e.v);
                end
                n_tests++;
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL latency: got cycle %0d required cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    function automatic cvec_t model(row_t a);
        cvec_t r;
        int ak, wk;
        for (int c = 0; c < N; c++) begin
            r[c] = '0;
            for (int k = 0; k < N; k++) begin
                ak = $signed(a[k]);
                wk = $signed(wm[k][c]);
                r[c] = r[c] + ACC_W'(ak * wk);
            end
        end
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < N; i++) r[i] = W'($urandom);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_end();
        tick();
        bus.b_valid        = 1'b0;
        bus.stationaryCtrl = 1'b0;
        bus.a_valid        = 1'b0;
    endtask

    task automatic drive_b(row_t row);
        bus.b_valid = 1'b1;
        bus.b_ins   = row;
        for (int r = N - 1; r > 0; r--) shm[r] = shm[r-1];
        shm[0] = row;
    endtask

    task automatic drive_a(row_t v, cvec_t expv);
        exp_t x;
        bus.a_valid = 1'b1;
        bus.a_ins   = v;
        x.v   = expv;
        x.cyc = cyc + 1 + LAT;
        sb.push_back(x);
    endtask

    task automatic drive_commit();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_rule: busy=%b a_valid=%b required 0/0", bus.busy, bus.a_valid);
        end
        bus.stationaryCtrl = 1'b1;
        for (int r = 0; r < N; r++) wm[r] = shm[r];
    endtask

    // Row N-1 is sent first so that tile row r settles in shadow row r.
    task automatic load_tile(input row_t t[N]);
        for (int i = 0; i < N; i++) begin
            drive_b(t[N-1-i]);
            cycle_end();
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb.size() != 0 || bus.busy) && k < 300) begin
            tick();
            k++;
        end
        n_tests++;
        if (k >= 300) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, busy=%b, required 0/0", sb.size(), bus.busy);
        end
    endtask

    task automatic do_reset(int ncyc);
        rst = 1'b1;
        sb.delete();
        repeat (ncyc) begin
            bus.a_ins          = rand_row();
            bus.b_ins          = rand_row();
            bus.a_valid        = 1'($urandom_range(0, 1));
            bus.b_valid        = 1'($urandom_range(0, 1));
            bus.stationaryCtrl = 1'($urandom_range(0, 1));
            tick();
        end
        n_tests++;
        if (bus.c_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_c_outs: got %h required 0", bus.c_outs);
        end
        n_tests++;
        if (bus.c_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_c_valid: got %b required 0", bus.c_valid);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b required 0", bus.busy);
        end
        for (int r = 0; r < N; r++) begin
            shm[r] = '0;
            wm[r]  = '0;
        end
        rst                = 1'b0;
        bus.a_valid        = 1'b0;
        bus.b_valid        = 1'b0;
        bus.stationaryCtrl = 1'b0;
        bus.a_ins          = '0;
        bus.b_ins          = '0;
    endtask

    initial begin
        row_t  v;
        cvec_t x;
        int    last;
        int    k;

        bus.a_valid        = 1'b0;
        bus.b_valid        = 1'b0;
        bus.stationaryCtrl = 1'b0;
        bus.a_ins          = '0;
        bus.b_ins          = '0;
        tick();
        do_reset(2);

        // Zero weights after reset.
        drive_a(rand_row(), '0);
        cycle_end();
        wait_idle();

        // Identity weights: output equals input.
        for (int r = 0; r < N; r++) begin
            t1[r]    = '0;
            t1[r][r] = 8'd1;
        end
        load_tile(t1);
        drive_commit();
        cycle_end();
        for (int i = 0; i < N; i++) begin
            v[i] = W'(i + 1);
            x[i] = ACC_W'(i + 1);
        end
        drive_a(v, x);
        cycle_end();
        wait_idle();

        // Signed extremes.
        for (int r = 0; r < N; r++) t1[r] = {N{8'h80}};
        load_tile(t1);
        drive_commit();
        cycle_end();
        drive_a({N{8'h80}}, {N{32'h0004_0000}});
        cycle_end();
        drive_a({N{8'h7F}}, {N{32'hFFFC_0800}});
        cycle_end();
        wait_idle();

        // Streaming 20 on, 3 off, 5 on against a random tile.
        for (int r = 0; r < N; r++) t1[r] = rand_row();
        load_tile(t1);
        drive_commit();
        cycle_end();
        for (int i = 0; i < 28; i++) begin
            if (i < 20 || i >= 23) begin
                v = rand_row();
                drive_a(v, model(v));
            end
            cycle_end();
        end
        last = sb[$].cyc;
        k = 0;
        while (cyc < last && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (bus.busy !== 1'b1 || bus.c_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_last: busy=%b c_valid=%b at cycle %0d required 1/1", bus.busy, bus.c_valid, cyc);
        end
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: got %b at cycle %0d required 0", bus.busy, cyc);
        end
        tick();

        // Load the next tile while vectors still run on the current one.
        for (int r = 0; r < N; r++) t2[r] = rand_row();
        for (int i = 0; i < N; i++) begin
            drive_b(t2[N-1-i]);
            if (i < 8) begin
                av[i] = rand_row();
                drive_a(av[i], model(av[i]));
            end
            cycle_end();
        end
        wait_idle();
        drive_commit();
        cycle_end();
        for (int i = 0; i < 8; i++) begin
            drive_a(av[i], model(av[i]));
            cycle_end();
        end
        wait_idle();

        // Commit coinciding with the first row of the following tile.
        for (int r = 0; r < N; r++) t1[r] = rand_row();
        load_tile(t1);
        drive_commit();
        drive_b(rand_row());
        cycle_end();
        for (int i = 0; i < 3; i++) begin
            v = rand_row();
            drive_a(v, model(v));
            cycle_end();
        end
        wait_idle();

        // Reset 10 cycles after the first of 8 in-flight vectors.
        for (int i = 0; i < 8; i++) begin
            v = rand_row();
            drive_a(v, model(v));
            cycle_end();
        end
        tick();
        tick();
        do_reset(2);
        repeat (45) tick();
        drive_a(rand_row(), '0);
        cycle_end();
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
